// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words and writes them to sequential word addresses while holding the CPU.
//
//   state | meaning
//   IDLE  | waiting for LoadStart, CPU free
//   RECV  | accepting bytes into the word assembly register
//   WRITE | one-cycle write strobe of the assembled word
//   DONE  | one-cycle LoadDone pulse, then back to IDLE
module imem_loader #(
    parameter int ADDR_W    = 7,
    parameter int MAX_WORDS = 82
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              LoadStart,
    input  logic [ADDR_W:0]   WordCnt,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [31:0]       WrData,
    output logic              CpuHold,
    output logic              LoadDone
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MaxWords = (ADDR_W + 1)'(MAX_WORDS);

    state_t            state_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   addr_q;
    logic [1:0]        k_q;
    logic [31:0]       asm_q;
    logic              rdy_q;
    logic              wren_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              hold_q;
    logic              done_q;

    logic [ADDR_W:0]   n_start_d;
    logic [ADDR_W:0]   addr_inc_d;

    // Address kept one bit wider than WrAddr so a full 2^ADDR_W load terminates.
    assign n_start_d  = (WordCnt > MaxWords) ? MaxWords : WordCnt;
    assign addr_inc_d = addr_q + (ADDR_W + 1)'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            n_q     <= '0;
            addr_q  <= '0;
            k_q     <= 2'd0;
            asm_q   <= '0;
            rdy_q   <= 1'b0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (LoadStart) begin
                        n_q    <= n_start_d;
                        addr_q <= '0;
                        k_q    <= 2'd0;
                        hold_q <= 1'b1;
                        if (n_start_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RECV;
                            rdy_q   <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (ByteValid) begin
                        asm_q[{k_q, 3'b000} +: 8] <= ByteIn;
                        k_q <= k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            state_q <= WRITE;
                            rdy_q   <= 1'b0;
                            wren_q  <= 1'b1;
                            waddr_q <= addr_q[ADDR_W-1:0];
                            wdata_q <= {ByteIn, asm_q[23:0]};
                        end
                    end
                end
                WRITE: begin
                    addr_q <= addr_inc_d;
                    if (addr_inc_d == n_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RECV;
                        rdy_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    hold_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b0;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ByteReady = rdy_q;
    assign WrEn      = wren_q;
    assign WrAddr    = waddr_q;
    assign WrData    = wdata_q;
    assign CpuHold   = hold_q;
    assign LoadDone  = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a load-level reference model checked every cycle,
// plus directed loads with literal expectations.
module tb_imem_loader;

    localparam int ADDR_W = 7;
    localparam int MAXW   = 82;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              LoadStart = 1'b0;
    logic [ADDR_W:0]   WordCnt = '0;
    logic [7:0]        ByteIn = '0;
    logic              ByteValid = 1'b0;
    logic              ByteReady;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [31:0]       WrData;
    logic              CpuHold;
    logic              LoadDone;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rstn(rstn), .LoadStart(LoadStart), .WordCnt(WordCnt),
        .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .CpuHold(CpuHold), .LoadDone(LoadDone)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a load is "busy" from the accepted start until its done pulse;
    // every fourth consumed byte produces one write cycle at the next word address.
    bit        m_busy = 0, m_wr = 0, m_done = 0;
    int        m_n = 0, m_addr = 0, m_k = 0;
    logic [7:0] m_b [4];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 0; m_wr <= 0; m_done <= 0;
            m_n <= 0; m_addr <= 0; m_k <= 0;
        end else if (m_wr) begin
            m_wr   <= 0;
            m_addr <= m_addr + 1;
            if (m_addr + 1 == m_n) m_done <= 1;
        end else if (m_done) begin
            m_done <= 0;
            m_busy <= 0;
        end else if (!m_busy) begin
            if (LoadStart) begin
                m_n    <= (int'(WordCnt) > MAXW) ? MAXW : int'(WordCnt);
                m_addr <= 0;
                m_k    <= 0;
                m_busy <= 1;
                if (WordCnt == 0) m_done <= 1;
            end
        end else if (ByteValid) begin
            m_b[m_k] <= ByteIn;
            m_k      <= (m_k + 1) % 4;
            if (m_k == 3) m_wr <= 1;
        end
    end

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          c;
    } wr_t;
    wr_t wr_log[$];
    int  done_cyc = -1;
    bit  hs = 0;

    always @(posedge clk) hs <= ByteValid && ByteReady;

    always @(negedge clk) begin
        if (rstn) begin
            chk("ByteReady", ByteReady, m_busy && !m_wr && !m_done);
            chk("WrEn", WrEn, m_wr);
            chk("CpuHold", CpuHold, m_busy);
            chk("LoadDone", LoadDone, m_done);
            if (m_wr) begin
                chk("WrAddr", WrAddr, m_addr);
                chk("WrData", WrData, {m_b[3], m_b[2], m_b[1], m_b[0]});
            end
            if (WrEn) wr_log.push_back('{int'(WrAddr), WrData, cyc});
            if (LoadDone) done_cyc = cyc;
        end
    end

    logic [7:0] byte_q[$];

    task automatic start(input int cnt);
        @(negedge clk);
        wr_log.delete();
        done_cyc  = -1;
        LoadStart = 1'b1;
        WordCnt   = cnt[ADDR_W:0];
    endtask

    // mode 0: back to back, 1: ByteValid toggles every cycle, 2: random gaps
    task automatic stream(input int mode, input int inj_at);
        int idx = 0;
        int c = 0;
        bit ph = 1;
        bit injected = 0;
        while (idx < byte_q.size() && c < 4000) begin
            @(negedge clk);
            c++;
            if (hs) idx++;
            LoadStart = 1'b0;
            if (idx >= byte_q.size()) break;
            if (idx == inj_at && !injected) begin
                LoadStart = 1'b1;
                WordCnt   = 8'd5;
                injected  = 1;
            end
            case (mode)
                0: ByteValid = 1'b1;
                1: begin ByteValid = ph; ph = !ph; end
                default: ByteValid = ($urandom_range(0, 2) != 0);
            endcase
            ByteIn = ByteValid ? byte_q[idx] : 8'($urandom);
        end
        ByteValid = 1'b0;
        LoadStart = 1'b0;
        if (idx < byte_q.size()) chk("stream_timeout", idx, byte_q.size());
    endtask

    task automatic wait_idle();
        int c = 0;
        @(negedge clk);
        LoadStart = 1'b0;
        while (CpuHold && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("idle_timeout", CpuHold, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_bytes(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ByteReady"}, ByteReady, 0);
        chk({tag, "_WrEn"}, WrEn, 0);
        chk({tag, "_WrAddr"}, WrAddr, 0);
        chk({tag, "_WrData"}, WrData, 0);
        chk({tag, "_CpuHold"}, CpuHold, 0);
        chk({tag, "_LoadDone"}, LoadDone, 0);
    endtask

    initial begin
        int s_cyc;
        int bad;
        logic [31:0] w;

        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Two-word directed load
        byte_q = '{8'h0E, 8'h0F, 8'h00, 8'h00, 8'h82, 8'h80, 8'h80, 8'h00};
        start(2);
        stream(0, -1);
        wait_idle();
        chk("two_cnt", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("two_a0", wr_log[0].addr, 0);
            chk("two_d0", wr_log[0].data, 32'h00000F0E);
            chk("two_a1", wr_log[1].addr, 1);
            chk("two_d1", wr_log[1].data, 32'h00808082);
            chk("two_done", done_cyc, wr_log[1].c + 1);
        end

        // Backpressure: ByteValid toggling
        byte_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        start(1);
        stream(1, -1);
        wait_idle();
        chk("bp_cnt", wr_log.size(), 1);
        if (wr_log.size() == 1) chk("bp_data", wr_log[0].data, 32'hDEADBEEF);

        // Zero-length load
        start(0);
        s_cyc = cyc;
        wait_idle();
        chk("zero_cnt", wr_log.size(), 0);
        chk("zero_done", done_cyc, s_cyc + 1);

        // Oversized request clamps to MAX_WORDS
        rand_bytes(MAXW * 4);
        start(200);
        stream(0, -1);
        wait_idle();
        chk("clamp_cnt", wr_log.size(), MAXW);
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i].addr != i) bad++;
        chk("clamp_addrs", bad, 0);

        // Ignored LoadStart mid-load
        rand_bytes(12);
        start(3);
        stream(2, 5);
        wait_idle();
        chk("ign_cnt", wr_log.size(), 3);

        // Reset after two bytes of word 3
        rand_bytes(14);
        start(5);
        stream(0, -1);
        #2 rstn = 1'b0;
        #1 check_outputs_zero("midrst");
        chk("midrst_cnt", wr_log.size(), 3);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_nodone", done_cyc, -1);
        rand_bytes(4);
        w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
        start(1);
        stream(0, -1);
        wait_idle();
        chk("fresh_cnt", wr_log.size(), 1);
        if (wr_log.size() == 1) begin
            chk("fresh_addr", wr_log[0].addr, 0);
            chk("fresh_data", wr_log[0].data, w);
        end

        // Random loads
        for (int t = 0; t < 10; t++) begin
            int cnt;
            int n;
            cnt = (t == 7) ? $urandom_range(83, 255) : $urandom_range(0, 12);
            n = (cnt > MAXW) ? MAXW : cnt;
            rand_bytes(n * 4);
            start(cnt);
            stream($urandom_range(0, 2), -1);
            wait_idle();
            chk("rand_cnt", wr_log.size(), n);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
